la_timer_bank: RTL and testbench
================================

LA_TIMER_BANK -- requirements
Module: la_timer_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16, counter/limit/data width in bits.
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent counter channels.
REQ-003 SHALL have parameter CH_BITS, default 2, width of channel index (2**CH_BITS >= CHANNELS).
REQ-004 SHALL have parameter DEFAULT_LIMIT, default 1000, reset value of every channel limit.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 cmd_valid  input  1  command present this cycle; sampled every edge, no back-pressure.
REQ-008 cmd_op  input  2  00 LOAD, 01 START, 10 STOP, 11 SET_LIMIT.
REQ-009 cmd_ch  input  CH_BITS  target channel.
REQ-010 cmd_data  input  WIDTH  preload value (LOAD) or limit value (SET_LIMIT); ignored otherwise.
REQ-011 mode  input  CHANNELS  per-channel: 0 one-shot, 1 auto-reload; sampled at terminal event.
REQ-012 cmd_ack  output  1  registered pulse, one cycle after each accepted cmd_valid.
REQ-013 cmd_err  output  1  qualifies cmd_ack: command was illegal and had no effect.
REQ-014 busy  output  CHANNELS  bit i high while channel i in RUN.
REQ-015 done  output  CHANNELS  bit i one-cycle pulse per terminal event of channel i.
REQ-016 result  output  WIDTH*CHANNELS  channel i slice [i*WIDTH +: WIDTH] = count captured at last terminal event.

Function
REQ-017 Each channel SHALL hold registers count, preload, limit, result and a state in {IDLE, ARMED, RUN, DONE}.
REQ-018 LOAD in IDLE, ARMED or DONE SHALL set preload and count to cmd_data and enter ARMED; LOAD in RUN SHALL be an error.
REQ-019 START in ARMED SHALL enter RUN with count unchanged; START in any other state SHALL be an error.
REQ-020 STOP in RUN SHALL enter ARMED holding count; STOP in any other state SHALL be an error.
REQ-021 SET_LIMIT SHALL be legal in every state and update limit; a RUN compare on the same edge SHALL use the old limit.
REQ-022 cmd_ch >= CHANNELS SHALL be an error; no channel state changes.
REQ-023 cmd_ack SHALL be 1 in the cycle after every cmd_valid cycle; cmd_err 1 in that cycle only for errors.
REQ-024 In RUN, per edge: if count >= limit -> terminal event; else count <= count + 1 (WIDTH-bit, never wraps, since terminal fires first at all-ones limit).
REQ-025 Terminal event SHALL set result <= count and pulse done for the following cycle.
REQ-026 Terminal with mode=0 SHALL enter DONE; with mode=1 SHALL reload count <= preload and stay in RUN.
REQ-027 DONE SHALL return to IDLE on the next edge, holding count and result.
REQ-028 Latency: with preload P <= limit L, done SHALL assert L-P+1 cycles after the START cycle; preload > limit gives terminal on the first RUN edge.
REQ-029 A STOP on a channel's terminal edge SHALL lose: terminal event occurs, STOP is processed against the resulting state (error if DONE, legal if reloaded RUN and takes effect next edge... i.e. STOP honoured only when state is RUN after terminal with mode=1, then enters ARMED).
REQ-030 Channels SHALL operate independently; one command per cycle affects at most one channel.

Reset
REQ-031 rst SHALL set all states IDLE, count/preload/result 0, limit DEFAULT_LIMIT, busy/done/cmd_ack/cmd_err 0.
REQ-032 rst during RUN SHALL abort without a done pulse; rst has priority over any command in that cycle.

Verification
REQ-033 LOAD ch0=0, SET_LIMIT ch0=3, START ch0, mode0=0 -> busy[0] 4 cycles, done[0] pulse 4 cycles after START, result ch0=3, state IDLE.
REQ-034 ch1 mode=1, preload 5, limit 7, START -> done[1] every 3 cycles, result ch1=7, busy[1] stays 1; STOP -> ARMED, busy[1]=0.
REQ-035 START on IDLE ch2, LOAD on RUN ch0, cmd_ch=4 (CHANNELS=4) -> cmd_ack=1,cmd_err=1 each, no state change.
REQ-036 Limit 0xFFFF, preload 0xFFFE -> terminal at 0xFFFF, result 0xFFFF, no wrap to 0.
REQ-037 rst asserted mid-RUN on ch3 -> next cycle busy=0, done=0, limit=1000, count=0.
REQ-038 All four channels started same preload/limit on consecutive cycles -> done pulses on consecutive cycles in start order.

Source files
------------

// File: rtl/la_timer_bank.sv
// Bank of independent up-counting timers driven by a one-command-per-cycle bus.
// cmd_ack/cmd_err one cycle after cmd_valid; done pulses one cycle after a terminal compare; no back-pressure.
module la_timer_bank #(
  parameter int WIDTH         = 16,
  parameter int CHANNELS      = 4,
  parameter int CH_BITS       = 2,
  parameter int DEFAULT_LIMIT = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  input  logic [1:0]                cmd_op,
  input  logic [CH_BITS-1:0]        cmd_ch,
  input  logic [WIDTH-1:0]          cmd_data,
  input  logic [CHANNELS-1:0]       mode,
  output logic                      cmd_ack,
  output logic                      cmd_err,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic [WIDTH*CHANNELS-1:0] result
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN, ST_DONE} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_LIMIT = 2'b11;

  state_t           state_q   [CHANNELS];
  logic [WIDTH-1:0] count_q   [CHANNELS];
  logic [WIDTH-1:0] preload_q [CHANNELS];
  logic [WIDTH-1:0] limit_q   [CHANNELS];
  logic [WIDTH-1:0] result_q  [CHANNELS];

  state_t           st_mid    [CHANNELS];
  state_t           st_nxt    [CHANNELS];
  logic [WIDTH-1:0] cnt_nxt   [CHANNELS];
  logic [WIDTH-1:0] pre_nxt   [CHANNELS];
  logic [WIDTH-1:0] lim_nxt   [CHANNELS];
  logic [CHANNELS-1:0] term;
  logic [CHANNELS-1:0] bad;
  logic                ch_ok;

  assign ch_ok = (int'(cmd_ch) < CHANNELS);

  // The run/terminal step is resolved first; a command on the same edge is
  // then judged against the post-step state, so a terminal always wins.
  always_comb begin
    term = '0;
    bad  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      st_mid[i]  = state_q[i];
      cnt_nxt[i] = count_q[i];
      pre_nxt[i] = preload_q[i];
      lim_nxt[i] = limit_q[i];
      case (state_q[i])
        ST_RUN: begin
          if (count_q[i] >= limit_q[i]) begin
            term[i] = 1'b1;
            if (mode[i]) cnt_nxt[i] = preload_q[i];
            else         st_mid[i]  = ST_DONE;
          end else begin
            cnt_nxt[i] = count_q[i] + WIDTH'(1);
          end
        end
        ST_DONE: st_mid[i] = ST_IDLE;
        default: ;
      endcase
      st_nxt[i] = st_mid[i];

      if (cmd_valid && ch_ok && (cmd_ch == CH_BITS'(i))) begin
        case (cmd_op)
          OP_LOAD: begin
            if (st_mid[i] == ST_RUN) begin
              bad[i] = 1'b1;
            end else begin
              pre_nxt[i] = cmd_data;
              cnt_nxt[i] = cmd_data;
              st_nxt[i]  = ST_ARMED;
            end
          end
          OP_START: begin
            if (st_mid[i] == ST_ARMED) st_nxt[i] = ST_RUN;
            else                       bad[i]    = 1'b1;
          end
          OP_STOP: begin
            if (st_mid[i] == ST_RUN) st_nxt[i] = ST_ARMED;
            else                     bad[i]    = 1'b1;
          end
          OP_LIMIT: lim_nxt[i] = cmd_data;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]   <= ST_IDLE;
        count_q[i]   <= '0;
        preload_q[i] <= '0;
        limit_q[i]   <= WIDTH'(DEFAULT_LIMIT);
        result_q[i]  <= '0;
      end
      done    <= '0;
      cmd_ack <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]   <= st_nxt[i];
        count_q[i]   <= cnt_nxt[i];
        preload_q[i] <= pre_nxt[i];
        limit_q[i]   <= lim_nxt[i];
        if (term[i]) result_q[i] <= count_q[i];
      end
      done    <= term;
      cmd_ack <= cmd_valid;
      cmd_err <= cmd_valid && (!ch_ok || (|bad));
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < CHANNELS; i++) busy[i] = (state_q[i] == ST_RUN);
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_result
    assign result[g*WIDTH +: WIDTH] = result_q[g];
  end

endmodule

// File: tb/tb_la_timer_bank.sv
// Directed bench for la_timer_bank: commands driven and outputs sampled on the falling edge.
module tb_la_timer_bank;
  localparam int W   = 16;
  localparam int NCH = 4;
  localparam int CB  = 3;
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_LIMIT = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [CB-1:0]    cmd_ch = '0;
  logic [W-1:0]     cmd_data = '0;
  logic [NCH-1:0]   mode = '0;
  logic             cmd_ack, cmd_err;
  logic [NCH-1:0]   busy, done;
  logic [W*NCH-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  la_timer_bank #(.WIDTH(W), .CHANNELS(NCH), .CH_BITS(CB), .DEFAULT_LIMIT(1000)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ch(cmd_ch),
    .cmd_data(cmd_data), .mode(mode), .cmd_ack(cmd_ack), .cmd_err(cmd_err),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Caller sits on a falling edge; returns on the falling edge after the command edge.
  task automatic issue(input logic [1:0] op, input int ch, input logic [W-1:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_ch = CB'(ch); cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy: got %b want 0000", busy); end
    n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b want 0000", done); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++; if (cmd_ack !== 1'b0 || cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b%b want 00", cmd_ack, cmd_err); end
    rst = 1'b0;
  endtask

  task automatic test_oneshot();
    int nb = 0, nd = 0, da = -1;
    mode[0] = 1'b0;
    issue(OP_LOAD, 0, 16'd0);
    n_checks++; if (cmd_ack !== 1'b1 || cmd_err !== 1'b0) begin n_fail++; $display("FAIL oneshot_load_ack: got %b%b want 10", cmd_ack, cmd_err); end
    issue(OP_LIMIT, 0, 16'd3);
    issue(OP_START, 0, 16'd0);
    for (int k = 0; k < 10; k++) begin
      if (busy[0]) nb++;
      if (done[0]) begin nd++; if (da < 0) da = k; end
      @(negedge clk);
    end
    n_checks++; if (nb != 4) begin n_fail++; $display("FAIL oneshot_busy_cycles: got %0d want 4", nb); end
    n_checks++; if (da != 4) begin n_fail++; $display("FAIL oneshot_done_latency: got %0d want 4", da); end
    n_checks++; if (nd != 1) begin n_fail++; $display("FAIL oneshot_done_count: got %0d want 1", nd); end
    n_checks++; if (result[0 +: W] !== 16'd3) begin n_fail++; $display("FAIL oneshot_result: got %0d want 3", result[0 +: W]); end
    issue(OP_START, 0, 16'd0);
    n_checks++; if (cmd_err !== 1'b1 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_idle_after: err=%b busy=%b want err=1 busy=0", cmd_err, busy[0]); end
  endtask

  task automatic test_reload();
    logic [9:0] pat = '0;
    logic       all_busy = 1'b1;
    mode[1] = 1'b1;
    issue(OP_LOAD, 1, 16'd5);
    issue(OP_LIMIT, 1, 16'd7);
    issue(OP_START, 1, 16'd0);
    for (int k = 0; k < 10; k++) begin
      pat[k] = done[1];
      all_busy &= busy[1];
      if (k < 9) @(negedge clk);
    end
    n_checks++; if (pat !== 10'h248) begin n_fail++; $display("FAIL reload_done_pattern: got %b want 1001001000", pat); end
    n_checks++; if (all_busy !== 1'b1) begin n_fail++; $display("FAIL reload_busy: got %b want 1", all_busy); end
    n_checks++; if (result[W +: W] !== 16'd7) begin n_fail++; $display("FAIL reload_result: got %0d want 7", result[W +: W]); end
    issue(OP_STOP, 1, 16'd0);
    n_checks++; if (cmd_ack !== 1'b1 || cmd_err !== 1'b0) begin n_fail++; $display("FAIL reload_stop_ack: got %b%b want 10", cmd_ack, cmd_err); end
    n_checks++; if (busy[1] !== 1'b0 || done[1] !== 1'b0) begin n_fail++; $display("FAIL reload_stop_state: busy=%b done=%b want 0 0", busy[1], done[1]); end
  endtask

  task automatic test_stop_on_terminal();
    // ch1 is ARMED holding count 6, preload 5, limit 7
    issue(OP_START, 1, 16'd0);
    @(negedge clk);
    issue(OP_STOP, 1, 16'd0);
    n_checks++; if (done[1] !== 1'b1) begin n_fail++; $display("FAIL stopterm_reload_done: got %b want 1", done[1]); end
    n_checks++; if (cmd_err !== 1'b0 || busy[1] !== 1'b0) begin n_fail++; $display("FAIL stopterm_reload_stop: err=%b busy=%b want 0 0", cmd_err, busy[1]); end
    mode[1] = 1'b0;
    issue(OP_START, 1, 16'd0);
    repeat (2) @(negedge clk);
    issue(OP_STOP, 1, 16'd0);
    n_checks++; if (done[1] !== 1'b1) begin n_fail++; $display("FAIL stopterm_oneshot_done: got %b want 1", done[1]); end
    n_checks++; if (cmd_ack !== 1'b1 || cmd_err !== 1'b1) begin n_fail++; $display("FAIL stopterm_oneshot_err: got %b%b want 11", cmd_ack, cmd_err); end
    n_checks++; if (result[W +: W] !== 16'd7) begin n_fail++; $display("FAIL stopterm_result: got %0d want 7", result[W +: W]); end
  endtask

  task automatic test_errors();
    issue(OP_LIMIT, 0, 16'd100);
    issue(OP_LOAD, 0, 16'd0);
    issue(OP_START, 0, 16'd0);
    issue(OP_START, 2, 16'd0);
    n_checks++; if (cmd_ack !== 1'b1 || cmd_err !== 1'b1) begin n_fail++; $display("FAIL err_start_idle: got %b%b want 11", cmd_ack, cmd_err); end
    issue(OP_LOAD, 0, 16'd50);
    n_checks++; if (cmd_ack !== 1'b1 || cmd_err !== 1'b1) begin n_fail++; $display("FAIL err_load_run: got %b%b want 11", cmd_ack, cmd_err); end
    issue(OP_START, 4, 16'd0);
    n_checks++; if (cmd_ack !== 1'b1 || cmd_err !== 1'b1) begin n_fail++; $display("FAIL err_bad_channel: got %b%b want 11", cmd_ack, cmd_err); end
    n_checks++; if (busy !== 4'b0001) begin n_fail++; $display("FAIL err_no_change: busy got %b want 0001", busy); end
    issue(OP_STOP, 0, 16'd0);
    n_checks++; if (cmd_err !== 1'b0 || busy !== 4'b0000) begin n_fail++; $display("FAIL err_stop_legal: err=%b busy=%b want 0 0000", cmd_err, busy); end
    @(negedge clk);
    n_checks++; if (cmd_ack !== 1'b0) begin n_fail++; $display("FAIL err_ack_pulse: got %b want 0", cmd_ack); end
  endtask

  task automatic test_boundary();
    int da = -1;
    mode[2] = 1'b0;
    issue(OP_LIMIT, 2, 16'hFFFF);
    issue(OP_LOAD, 2, 16'hFFFE);
    issue(OP_START, 2, 16'd0);
    for (int k = 0; k < 6; k++) begin
      if (done[2] && da < 0) da = k;
      @(negedge clk);
    end
    n_checks++; if (da != 2) begin n_fail++; $display("FAIL bound_max_latency: got %0d want 2", da); end
    n_checks++; if (result[2*W +: W] !== 16'hFFFF) begin n_fail++; $display("FAIL bound_max_result: got %h want ffff", result[2*W +: W]); end
    da = -1;
    issue(OP_LOAD, 2, 16'd10);
    issue(OP_LIMIT, 2, 16'd5);
    issue(OP_START, 2, 16'd0);
    for (int k = 0; k < 6; k++) begin
      if (done[2] && da < 0) da = k;
      @(negedge clk);
    end
    n_checks++; if (da != 1) begin n_fail++; $display("FAIL bound_pre_gt_lim_latency: got %0d want 1", da); end
    n_checks++; if (result[2*W +: W] !== 16'd10) begin n_fail++; $display("FAIL bound_pre_gt_lim_result: got %0d want 10", result[2*W +: W]); end
  endtask

  task automatic test_back_to_back();
    int first [NCH];
    int cnt   [NCH];
    int errs = 0;
    mode = '0;
    for (int c = 0; c < NCH; c++) begin
      first[c] = -1; cnt[c] = 0;
      issue(OP_LOAD, c, 16'd0);
      issue(OP_LIMIT, c, 16'd2);
    end
    cmd_valid = 1'b1; cmd_op = OP_START; cmd_ch = '0;
    @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if (done[c]) begin cnt[c]++; if (first[c] < 0) first[c] = n; end
      end
      if (cmd_err) errs++;
      if (n < 3) cmd_ch = CB'(n + 1);
      else       cmd_valid = 1'b0;
      @(negedge clk);
    end
    for (int c = 0; c < NCH; c++) begin
      n_checks++; if (first[c] != c + 3 || cnt[c] != 1) begin n_fail++; $display("FAIL b2b_done_ch%0d: at %0d x%0d want at %0d x1", c, first[c], cnt[c], c + 3); end
    end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL b2b_errors: got %0d want 0", errs); end
  endtask

  task automatic test_reset_run();
    int da = -1;
    issue(OP_LIMIT, 3, 16'd500);
    issue(OP_LOAD, 3, 16'd0);
    issue(OP_START, 3, 16'd0);
    repeat (3) @(negedge clk);
    n_checks++; if (busy[3] !== 1'b1) begin n_fail++; $display("FAIL rstrun_running: got %b want 1", busy[3]); end
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_op = OP_STOP; cmd_ch = CB'(3);
    @(negedge clk);
    n_checks++; if (busy !== 4'b0000 || done !== 4'b0000) begin n_fail++; $display("FAIL rstrun_outputs: busy=%b done=%b want 0000 0000", busy, done); end
    n_checks++; if (cmd_ack !== 1'b0 || cmd_err !== 1'b0) begin n_fail++; $display("FAIL rstrun_ack: got %b%b want 00", cmd_ack, cmd_err); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL rstrun_result: got %h want 0", result); end
    rst = 1'b0; cmd_valid = 1'b0;
    issue(OP_START, 3, 16'd0);
    n_checks++; if (cmd_err !== 1'b1) begin n_fail++; $display("FAIL rstrun_idle: err got %b want 1", cmd_err); end
    issue(OP_LOAD, 3, 16'd990);
    issue(OP_START, 3, 16'd0);
    for (int k = 0; k < 16; k++) begin
      if (done[3] && da < 0) da = k;
      @(negedge clk);
    end
    n_checks++; if (da != 11) begin n_fail++; $display("FAIL rstrun_default_limit: latency %0d want 11", da); end
    n_checks++; if (result[3*W +: W] !== 16'd1000) begin n_fail++; $display("FAIL rstrun_limit_result: got %0d want 1000", result[3*W +: W]); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, simulation not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_reload();
    test_stop_on_terminal();
    test_errors();
    test_boundary();
    test_back_to_back();
    test_reset_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
